// File: rtl/btle_tx_bit_serializer_pkg.sv
// Shared types and framing constants for the BLE 1M transmit bit serializer.
// The preamble is chosen so that its last bit on air differs from access address bit 0.
package btle_tx_bit_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ACCESS_ADDR,
        ST_HEADER,
        ST_PAYLOAD
    } state_t;

    localparam logic [7:0] PREAMBLE_AA0 = 8'hAA;
    localparam logic [7:0] PREAMBLE_AA1 = 8'h55;

    localparam int PREAMBLE_BITS = 8;
    localparam int AA_BITS       = 32;
    localparam int HEADER_BITS   = 16;
    localparam int HEADER_BYTES  = HEADER_BITS / 8;

    function automatic logic [7:0] preamble_for(input logic aa_bit0);
        return aa_bit0 ? PREAMBLE_AA1 : PREAMBLE_AA0;
    endfunction

endpackage

// File: rtl/btle_tx_bit_serializer_symbol_tick.sv
// Symbol slot counter: one-cycle tick every SAMPLE_PER_SYMBOL clocks.
// Restarting on an accepted start aligns the slot grid to the packet's first bit.
module btle_symbol_tick #(
    parameter int SAMPLE_PER_SYMBOL = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = (SAMPLE_PER_SYMBOL > 1) ? $clog2(SAMPLE_PER_SYMBOL) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PER_SYMBOL - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/btle_tx_bit_serializer.sv
// BLE 1M transmit bit serializer: preamble, access address, then PDU bytes, LSB first.
// state          | meaning
// ST_IDLE        | waiting for start (busy stays high one cycle after the last bit)
// ST_PREAMBLE    | 8 preamble bits, first one emitted on the accepting edge
// ST_ACCESS_ADDR | 32 access address bits
// ST_HEADER      | first two PDU bytes from the byte buffer
// ST_PAYLOAD     | len payload bytes from the byte buffer
module btle_tx_bit_serializer
    import btle_tx_bit_serializer_pkg::*;
#(
    parameter int SAMPLE_PER_SYMBOL = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] access_address,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    output logic        byte_in_ready,
    output logic        bit_out,
    output logic        bit_out_valid,
    output logic        bit_out_valid_last,
    output logic        busy,
    output logic        underrun
);
    state_t      state;
    logic [31:0] aa_reg;
    logic [4:0]  pos;
    logic [2:0]  bit_idx;
    logic [7:0]  buf_data;
    logic [7:0]  sh_data;
    logic [7:0]  len;
    logic        buf_full;
    logic        sh_valid;
    logic        len_known;
    logic [8:0]  bytes_acc;
    logic [8:0]  bytes_sent;

    logic        tick;
    logic        accept;
    logic        xfer;
    logic        pdu_slot;
    logic        have_bit;
    logic        cur_bit;
    logic        emit;
    logic        byte_done;
    logic        pdu_done;
    logic [8:0]  byte_limit;
    logic [7:0]  pre_start;
    logic [7:0]  pre_reg;

    btle_symbol_tick #(.SAMPLE_PER_SYMBOL(SAMPLE_PER_SYMBOL)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    assign accept        = start && !busy;
    assign byte_limit    = len_known ? 9'(HEADER_BYTES) + {1'b0, len} : 9'(HEADER_BYTES);
    assign byte_in_ready = busy && !buf_full && (bytes_acc < byte_limit);
    assign xfer          = byte_in_valid && byte_in_ready;

    // A byte still sitting in the holding register can be emitted directly after an underrun.
    assign have_bit  = sh_valid || buf_full;
    assign cur_bit   = sh_valid ? sh_data[bit_idx] : buf_data[bit_idx];
    assign pdu_slot  = tick && ((state == ST_HEADER) || (state == ST_PAYLOAD));
    assign emit      = pdu_slot && have_bit;
    assign byte_done = emit && (bit_idx == 3'd7);
    assign pdu_done  = byte_done && ((bytes_sent + 9'd1) == (9'(HEADER_BYTES) + {1'b0, len}));
    assign pre_start = preamble_for(access_address[0]);
    assign pre_reg   = preamble_for(aa_reg[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data   <= '0;
            buf_full   <= 1'b0;
            sh_data    <= '0;
            sh_valid   <= 1'b0;
            bit_idx    <= '0;
            len        <= '0;
            len_known  <= 1'b0;
            bytes_acc  <= '0;
            bytes_sent <= '0;
        end else if (accept) begin
            buf_full   <= 1'b0;
            sh_valid   <= 1'b0;
            bit_idx    <= '0;
            len        <= '0;
            len_known  <= 1'b0;
            bytes_acc  <= '0;
            bytes_sent <= '0;
        end else begin
            if (xfer) begin
                buf_data  <= byte_in;
                buf_full  <= 1'b1;
                bytes_acc <= bytes_acc + 9'd1;
                if (bytes_acc == 9'd1) begin
                    len       <= byte_in;
                    len_known <= 1'b1;
                end
            end
            if (emit) begin
                bit_idx <= bit_idx + 3'd1;
                if (!sh_valid) begin
                    sh_data  <= buf_data;
                    sh_valid <= 1'b1;
                    buf_full <= 1'b0;
                end else if (byte_done) begin
                    bytes_sent <= bytes_sent + 9'd1;
                    if (buf_full) begin
                        sh_data  <= buf_data;
                        buf_full <= 1'b0;
                    end else begin
                        sh_valid <= 1'b0;
                    end
                end
            end else if (!sh_valid && buf_full) begin
                sh_data  <= buf_data;
                sh_valid <= 1'b1;
                buf_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            aa_reg             <= '0;
            pos                <= '0;
            bit_out            <= 1'b0;
            bit_out_valid      <= 1'b0;
            bit_out_valid_last <= 1'b0;
            busy               <= 1'b0;
            underrun           <= 1'b0;
        end else begin
            bit_out_valid      <= 1'b0;
            bit_out_valid_last <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bit_out_valid_last) begin
                        busy <= 1'b0;
                    end
                    if (accept) begin
                        aa_reg        <= access_address;
                        busy          <= 1'b1;
                        underrun      <= 1'b0;
                        bit_out       <= pre_start[0];
                        bit_out_valid <= 1'b1;
                        pos           <= 5'd1;
                        state         <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (tick) begin
                        bit_out       <= pre_reg[pos[2:0]];
                        bit_out_valid <= 1'b1;
                        if (pos == 5'(PREAMBLE_BITS - 1)) begin
                            pos   <= '0;
                            state <= ST_ACCESS_ADDR;
                        end else begin
                            pos <= pos + 5'd1;
                        end
                    end
                end
                ST_ACCESS_ADDR: begin
                    if (tick) begin
                        bit_out       <= aa_reg[pos];
                        bit_out_valid <= 1'b1;
                        pos           <= pos + 5'd1;
                        if (pos == 5'(AA_BITS - 1)) begin
                            state <= ST_HEADER;
                        end
                    end
                end
                ST_HEADER, ST_PAYLOAD: begin
                    if (pdu_slot) begin
                        if (have_bit) begin
                            bit_out       <= cur_bit;
                            bit_out_valid <= 1'b1;
                            if (pdu_done) begin
                                bit_out_valid_last <= 1'b1;
                                state              <= ST_IDLE;
                            end else if (byte_done && (bytes_sent == 9'(HEADER_BYTES - 1))) begin
                                state <= ST_PAYLOAD;
                            end
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/btle_tx_bit_serializer.md
# btle_tx_bit_serializer

Front of the BLE 1M transmit bit chain: takes an access address and a byte stream of PDU header plus payload, and emits the on-air bit stream LSB-first. The stream is preamble (8 bits), then access address (32 bits), then PDU (16 + 8·len bits), one bit per symbol slot. It feeds the CRC24 stage, which feeds the whitening (scramble) stage. Both downstream stages rely on exactly 40 unprotected, unwhitened bits before the PDU, so the framing produced here is fixed.

## Interface
- SAMPLE_PER_SYMBOL, 8, clocks per output bit slot; legal 1..64
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request to begin a packet; ignored while busy
- access_address  in  32  sampled on accepted start
- byte_in  in  8  PDU byte: header byte 0, header byte 1 (length), then payload
- byte_in_valid  in  1  byte_in holds a byte
- byte_in_ready  out  1  serializer accepts byte_in this cycle
- bit_out  out  1  serialized bit
- bit_out_valid  out  1  one-cycle strobe per bit slot
- bit_out_valid_last  out  1  high with bit_out_valid on the final PDU bit
- busy  out  1  high from accepted start until the cycle after the last bit
- underrun  out  1  sticky; set when a bit slot finds no byte buffered; cleared on accepted start

## Operation
- Reset values: every output is 0; state is IDLE; all counters are 0; the byte buffer is empty.
- States:
  - IDLE: accepted start latches the AA, sets busy, and goes to PREAMBLE.
  - PREAMBLE: 8 bits.
  - ACCESS_ADDR: 32 bits.
  - HEADER: 16 bits.
  - PAYLOAD: 8·len bits.
  - Return to IDLE after the last bit.
- Preamble value: 0xAA when access_address[0]==0, else 0x55. Transmit LSB first, so the preamble's last bit always differs from AA bit 0.
- AA: bits 0..31 in order.
- Bytes: LSB first.
- Length: the value of header byte 1 (8 bits, 0..255) is latched when that byte enters the buffer.
- Payload: exactly len bytes follow the header.
- Byte buffer: one 8-bit holding register plus a shift register.
  - byte_in_ready = busy && buffer empty && bytes_accepted < 2+len. Until byte 1 has been received, the limit is 2.
  - A transfer happens when byte_in_valid && byte_in_ready.
  - The first byte may be transferred any time after start, including during the preamble.
  - When the shift register's 8th bit is emitted, the buffer moves into the shift register and the buffer empties.
- Underrun: if a HEADER/PAYLOAD bit slot arrives with no bit available, that slot emits nothing and sets underrun. The bit is emitted at the first slot boundary after the byte arrives. The slot grid is not re-phased.
- Counters:
  - Slot counter: 0..SAMPLE_PER_SYMBOL-1, wraps.
  - Bit index: 3 bits, wraps at 8.
  - Byte counter: 9 bits, so 2+255 does not overflow.

## Timing
- start sampled at edge t gives the first bit_out_valid in cycle t+1 (registered).
- Subsequent strobes occur every SAMPLE_PER_SYMBOL cycles. With SAMPLE_PER_SYMBOL=1 the strobe is continuous.
- bit_out is held until the next strobe.
- Total strobes = 56 + 8·len. bit_out_valid_last is asserted only on the last strobe.
- busy falls one cycle after the last strobe. A new start is accepted in the cycle busy is low.
- start while busy is ignored entirely; the latched AA is unchanged.
- rst mid-packet aborts immediately to reset values. No valid_last is emitted.
- byte_in_ready is combinational from registered state only. It never depends on byte_in_valid.

## Structure
- Shared package/header:
  - state encodings;
  - PREAMBLE_AA0 = 8'hAA and PREAMBLE_AA1 = 8'h55;
  - PREAMBLE_BITS = 8, AA_BITS = 32, HEADER_BITS = 16.
- One sub-module, btle_symbol_tick: slot counter producing the one-cycle tick. It restarts on accepted start so that the tick lands in cycle t+1.
- Everything else is a single FSM plus datapath in the top module.

## Test plan
- AA=0x8E89BED6, header 0x02,0x00, bytes always valid, SAMPLE_PER_SYMBOL=8:
  - first 8 bits are 0,1,0,1,0,1,0,1 (preamble 0xAA);
  - next 8 bits are 0,1,1,0,1,0,1,1 (AA byte 0xD6);
  - 56 strobes total, 8 cycles apart;
  - valid_last on strobe 56;
  - busy low at the cycle after it.
- AA=0x12345671 (bit 0 = 1), len=37, random payload:
  - preamble 0x55 (1,0,1,0,...);
  - 352 strobes;
  - payload bits match the bytes LSB first;
  - byte_in_ready goes low after 39 bytes.
- Underrun: len=4, byte_in_valid withheld for 20 cycles before payload byte 2.
  - underrun=1;
  - no strobe during the gap;
  - the correct bit sequence resumes on the slot grid;
  - total strobes still 88.
- start pulsed again mid-packet with a different AA: the output sequence is identical to the single-start reference.
- rst asserted at strobe 30, then a new start:
  - all outputs are 0 during rst;
  - the second packet is bit-exact from its preamble.
- SAMPLE_PER_SYMBOL=1, len=0: 56 consecutive strobe cycles, with start accepted again at the cycle busy falls.
